// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// Outputs are registered; every grant is followed by at least one idle cycle.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // Protocol: requester k raises req[k] and keeps it high while it uses the
    // resource; gnt[k] answers one cycle later. Dropping req[k] is the release,
    // and the hold limit revokes the grant with a one-cycle timeout pulse.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       idx_nxt;
    logic             valid_nxt;
    logic             to_nxt;
    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       cand;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt   = 4'b0000;
                idx_nxt   = 2'b00;
                valid_nxt = 1'b0;
                if (win_found) begin
                    state_nxt = GRANT;
                    idx_nxt   = win_idx;
                    gnt_nxt   = 4'b0001 << win_idx;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                // A release on the last allowed cycle is a normal release.
                if (!req[gnt_idx] || cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    idx_nxt   = 2'b00;
                    valid_nxt = 1'b0;
                    ptr_nxt   = gnt_idx + 2'd1;
                    cnt_nxt   = '0;
                    to_nxt    = req[gnt_idx];
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'b00;
            cnt       <= '0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= to_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: vector table, multi-cycle sequences,
// and a per-cycle invariant check on the grant outputs.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       to;
    } vec_t;

    vec_t tbl[19];

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] pack(input logic [3:0] g, input logic t);
        pack = {g, enc(g), |g, t};
    endfunction

    task automatic compare(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {gnt, gnt_idx, gnt_valid, timeout};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
                     name, got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Starts and ends on a falling edge; req is sampled at the rising edge between.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic et, input string name);
        req = r;
        exp_q.push_back(pack(eg, et));
        @(posedge clk);
        #1;
        compare(name, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n = 1'b0;
        req   = r;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tests++;
            if (!(((gnt & (gnt - 4'd1)) == 4'b0000) &&
                  (gnt_valid == |gnt) &&
                  (!gnt_valid || gnt == (4'b0001 << gnt_idx)) &&
                  (gnt_valid || gnt_idx == 2'd0) &&
                  !(timeout && gnt_valid))) begin
                fails++;
                $display("FAIL invariant: gnt=%b idx=%0d valid=%b timeout=%b, required one-hot gnt matching idx, no timeout while valid",
                         gnt, gnt_idx, gnt_valid, timeout);
            end
        end
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001, 1'b0};
        tbl[1]  = '{4'b1110, 4'b0000, 1'b0};
        tbl[2]  = '{4'b1110, 4'b0010, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0};
        tbl[5]  = '{4'b1011, 4'b1000, 1'b0};
        tbl[6]  = '{4'b0011, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0011, 4'b0001, 1'b0};
        tbl[8]  = '{4'b0010, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0011, 4'b0010, 1'b0};
        tbl[10] = '{4'b0001, 4'b0000, 1'b0};
        tbl[11] = '{4'b0001, 4'b0001, 1'b0};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{4'b0100, 4'b0100, 1'b0};
        tbl[14] = '{4'b0101, 4'b0100, 1'b0};
        tbl[15] = '{4'b1111, 4'b0100, 1'b0};
        tbl[16] = '{4'b1011, 4'b0000, 1'b0};
        tbl[17] = '{4'b1011, 4'b1000, 1'b0};
        tbl[18] = '{4'b0000, 4'b0000, 1'b0};

        // Reset with all requests held, then the vector table.
        do_reset(4'b1111);
        for (int i = 0; i < 19; i++)
            step(tbl[i].req, tbl[i].gnt, tbl[i].to, $sformatf("table[%0d]", i));

        // Rotation 0,1,2,3,0 with one idle cycle between owners.
        do_reset(4'b0000);
        step(4'b1111, 4'b0001, 1'b0, "rot_first");
        for (int i = 0; i < 5; i++) begin
            logic [3:0] oh;
            logic [3:0] oh_next;
            oh      = 4'b0001 << (i % 4);
            oh_next = 4'b0001 << ((i + 1) % 4);
            step(4'b1111, oh, 1'b0, "rot_hold");
            step(4'b1111, oh, 1'b0, "rot_hold");
            step(4'b1111 & ~oh, 4'b0000, 1'b0, "rot_release");
            if (i < 4)
                step(4'b1111, oh_next, 1'b0, "rot_next");
        end

        // Single requester hits the hold limit and is regranted.
        do_reset(4'b0000);
        for (int i = 0; i < 8; i++)
            step(4'b0100, 4'b0100, 1'b0, "to_hold");
        step(4'b0100, 4'b0000, 1'b1, "to_pulse");
        step(4'b0100, 4'b0100, 1'b0, "to_regrant");
        step(4'b0000, 4'b0000, 1'b0, "to_release");

        // Timed-out requester yields to the other active requester.
        do_reset(4'b0000);
        for (int i = 0; i < 8; i++)
            step(4'b0101, 4'b0001, 1'b0, "fair_hold");
        step(4'b0101, 4'b0000, 1'b1, "fair_pulse");
        step(4'b0101, 4'b0100, 1'b0, "fair_next");
        step(4'b0001, 4'b0000, 1'b0, "fair_release");
        step(4'b0001, 4'b0001, 1'b0, "fair_back");
        step(4'b0000, 4'b0000, 1'b0, "fair_end");

        // Release on the last allowed cycle is a normal release; ptr moves to 2.
        do_reset(4'b0000);
        for (int i = 0; i < 8; i++)
            step(4'b0010, 4'b0010, 1'b0, "sim_hold");
        step(4'b0000, 4'b0000, 1'b0, "sim_release");
        step(4'b1111, 4'b0100, 1'b0, "sim_ptr2");
        step(4'b0000, 4'b0000, 1'b0, "sim_end");

        // Asynchronous reset while requester 3 owns the grant.
        do_reset(4'b0000);
        step(4'b0100, 4'b0100, 1'b0, "mid_g2");
        step(4'b0000, 4'b0000, 1'b0, "mid_rel2");
        step(4'b1000, 4'b1000, 1'b0, "mid_g3");
        step(4'b1000, 4'b1000, 1'b0, "mid_hold3");
        #2;
        rst_n = 1'b0;
        req   = 4'b1111;
        #1;
        compare("async_reset", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 4'b0001, 1'b0, "mid_restart_ptr0");
        step(4'b0000, 4'b0000, 1'b0, "mid_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that time-shares one resource, such as a decoder-driven gate unit, between requesters.
- Selects a 2-bit owner index and drives it as a one-hot grant, equivalent to the decoded 2-to-4 output.
- Enforces a maximum hold time per grant so no requester can starve the others.
- Sits between requesting blocks and the shared resource in the Day-series logic designs.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold a grant (legal range 2..15).
- CNT_W, 4, width of the hold counter; must hold MAX_HOLD-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; bit k high = requester k wants the resource and keeps it high while using it.
- gnt  output  4  one-hot grant; all zero when no owner.
- gnt_idx  output  2  binary index of the current owner; 0 when gnt is zero.
- gnt_valid  output  1  high when any grant is active (equals OR of gnt).
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately, mid-grant included.
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- All outputs are registered; no combinational path from req to gnt.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If req==0: stay in IDLE, outputs stay zero.
  - Otherwise pick the first set req bit in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4, wrap-around).
  - On the next edge, load the winner into gnt_idx, set gnt = one-hot decode of gnt_idx, gnt_valid=1, counter=0, state=GRANT.
  - Latency: one cycle from req sampled to gnt visible.
- GRANT, evaluated each edge for owner o:
  - Normal release, req[o]==0: clear gnt, gnt_valid and gnt_idx next edge; ptr=o+1 mod 4; state=IDLE; timeout stays 0.
  - Timeout, req[o]==1 and counter==MAX_HOLD-1: clear the grant next edge; ptr=o+1 mod 4; timeout=1 for exactly that one cycle; state=IDLE.
  - Otherwise: counter increments; the grant is held unchanged.
  - The owner can hold for at most MAX_HOLD cycles with gnt high.
- Release and timeout in the same cycle (req[o] drops on the last allowed cycle): treated as a normal release, timeout stays 0.
- Every grant ends with at least one IDLE cycle where gnt==0. This is the mandatory turnaround and no back-to-back grants are allowed.
- Requests from non-owners during GRANT are ignored. They are re-arbitrated in the next IDLE cycle using the updated ptr.
- A requester that timed out and still requests is served again only after the other active requesters, which follows from the ptr rotation.
- Changes on req bits other than the owner's never affect the current grant.
- Invariants, checked every cycle:
  - gnt is zero or one-hot.
  - gnt == decode(gnt_idx) whenever gnt_valid=1.
  - timeout=1 implies gnt_valid=0 in the same cycle.

Test Plan:
- Reset with req=4'b1111 held, then release rst_n → one cycle after rst_n high, gnt=4'b0001, gnt_idx=0; after requester 0 drops req, one idle cycle, then gnt=4'b0010.
- Rotation: req=4'b1111 held, each owner drops its req bit 3 cycles into its grant and reasserts it in the following cycle → grants cycle 0,1,2,3,0 with one zero cycle between each.
- Timeout: MAX_HOLD=8, only req[2] high continuously → gnt=4'b0100 for exactly 8 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=4'b0100 again.
- Timeout fairness: req=4'b0101, requester 0 never drops → after the 8-cycle hold, timeout pulse, then gnt=4'b0100 (requester 2), not requester 0.
- Simultaneous release/limit: requester 1 drops req on its 8th granted cycle → gnt clears, timeout stays 0, ptr=2.
- Reset mid-grant: assert rst_n low asynchronously between edges while gnt=4'b1000 → gnt, gnt_idx, gnt_valid and timeout all zero immediately; after release, arbitration restarts from ptr=0.
